// File: rtl/pattern_det_pkg.sv
// Shared definitions for the serial pattern detector: detector state encoding,
// length-port width helper and the power-on pattern defaults.
package pattern_det_pkg;

    // FILL: fewer than len bits gathered since the last restart.
    // ARMED: at least len bits gathered, every accepted bit can match.
    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_ARMED = 1'b1
    } det_state_t;

    // Width of a length/fill field able to hold 0..pat_w (and pat_w+1 for
    // range checking of incoming lengths).
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

    localparam int         DEF_PAT_W   = 8;
    localparam logic [7:0] DEF_PATTERN = 8'b0001_1011;
    localparam int         DEF_LEN     = 5;
    localparam bit         DEF_OVERLAP = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky saturation flag.
// Clear has priority over increment; the flag sets on the increment that
// reaches all-ones and stays set until cleared or reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o,
    output logic         sat_o
);

    localparam logic [W-1:0] MAX_COUNT = '1;

    logic [W-1:0] r_count;
    logic         r_sat;

    // Count accepted increments, hold at all-ones, clear wins over increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (clear_i) begin
            r_count <= '0;
            r_sat   <= 1'b0;
        end else if (inc_i && (r_count != MAX_COUNT)) begin
            r_count <= r_count + W'(1);
            if (r_count == (MAX_COUNT - W'(1))) begin
                r_sat <= 1'b1;
            end
        end
    end

    assign count_o = r_count;
    assign sat_o   = r_sat;

endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial bit-pattern detector. Bits shift into a history
// register when qualified; a masked compare of the low len bits against the
// active pattern yields a registered one-cycle match pulse and bumps a
// saturating match counter. Overlap mode keeps the window armed after a
// match; non-overlap mode restarts filling from zero.
module seq_pattern_detector
    import pattern_det_pkg::*;
#(
    parameter int               PAT_W       = DEF_PAT_W,
    parameter int               CNT_W       = 16,
    parameter logic [PAT_W-1:0] RST_PATTERN = PAT_W'(DEF_PATTERN),
    parameter int               RST_LEN     = DEF_LEN,
    parameter bit               RST_OVERLAP = DEF_OVERLAP,
    localparam int              LEN_W       = len_width(PAT_W)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             d_i,
    input  logic             valid_i,
    input  logic             cfg_we_i,
    input  logic [PAT_W-1:0] cfg_pattern_i,
    input  logic [LEN_W-1:0] cfg_len_i,
    input  logic             cfg_overlap_i,
    input  logic             clear_i,
    output logic             pattern_detected_o,
    output logic [CNT_W-1:0] match_count_o,
    output logic             count_sat_o,
    output logic             cfg_err_o
);

    det_state_t       r_state;
    logic [PAT_W-1:0] r_hist;
    logic [LEN_W-1:0] r_fill;
    logic [PAT_W-1:0] r_pat;
    logic [LEN_W-1:0] r_len;
    logic             r_ovl;
    logic             r_pattern_detected;
    logic             r_cfg_err;

    logic [PAT_W-1:0] w_hist_next;
    logic [PAT_W-1:0] w_mask;
    logic [LEN_W-1:0] w_fill_plus1;
    logic [LEN_W-1:0] w_fill_inc;
    logic             w_accept;
    logic             w_fill_ready;
    logic             w_hit;
    logic             w_match;
    logic             w_cfg_len_ok;

    // Compare mask: bit gi takes part in the compare when gi < len.
    for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
        assign w_mask[gi] = (LEN_W'(gi) < r_len);
    end

    assign w_accept     = valid_i & ~cfg_we_i;
    assign w_hist_next  = {r_hist[PAT_W-2:0], d_i};
    assign w_fill_plus1 = r_fill + LEN_W'(1);
    assign w_fill_inc   = (r_fill == LEN_W'(PAT_W)) ? r_fill : w_fill_plus1;
    // Once ARMED the window is always full; in FILL the incoming bit completes
    // the window only when exactly len-1 bits are already present.
    assign w_fill_ready = (r_state == ST_ARMED) || (w_fill_plus1 == r_len);
    assign w_hit        = (((w_hist_next ^ r_pat) & w_mask) == '0);
    assign w_match      = w_accept & w_fill_ready & w_hit;
    assign w_cfg_len_ok = (cfg_len_i != '0) && (cfg_len_i <= LEN_W'(PAT_W));

    // Detector FSM: config loading, bit shifting, fill tracking and pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state            <= ST_FILL;
            r_hist             <= '0;
            r_fill             <= '0;
            r_pat              <= RST_PATTERN;
            r_len              <= LEN_W'(RST_LEN);
            r_ovl              <= RST_OVERLAP;
            r_pattern_detected <= 1'b0;
            r_cfg_err          <= 1'b0;
        end else begin
            r_pattern_detected <= 1'b0;
            r_cfg_err          <= 1'b0;
            if (cfg_we_i) begin
                // A config cycle never consumes d_i, legal or not.
                if (w_cfg_len_ok) begin
                    r_pat   <= cfg_pattern_i;
                    r_len   <= cfg_len_i;
                    r_ovl   <= cfg_overlap_i;
                    r_fill  <= '0;
                    r_state <= ST_FILL;
                end else begin
                    r_cfg_err <= 1'b1;
                end
            end else if (valid_i) begin
                r_hist <= w_hist_next;
                if (w_match) begin
                    r_pattern_detected <= 1'b1;
                    if (r_ovl) begin
                        r_fill  <= w_fill_inc;
                        r_state <= ST_ARMED;
                    end else begin
                        // History is left in place; fill=0 hides it.
                        r_fill  <= '0;
                        r_state <= ST_FILL;
                    end
                end else begin
                    r_fill  <= w_fill_inc;
                    r_state <= (w_fill_inc >= r_len) ? ST_ARMED : ST_FILL;
                end
            end
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .inc_i   (w_match),
        .count_o (match_count_o),
        .sat_o   (count_sat_o)
    );

    assign pattern_detected_o = r_pattern_detected;
    assign cfg_err_o          = r_cfg_err;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector. Two instances: the default
// configuration, and a 2-bit-counter instance with a single-bit pattern used
// for saturation/clear. Each driven cycle pushes its expected outputs to a
// scoreboard; a negedge monitor pops and compares them.
module tb_seq_pattern_detector;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Main instance
    logic        m_d, m_valid, m_we, m_ovl, m_clr;
    logic [7:0]  m_pat;
    logic [3:0]  m_len;
    logic        m_det, m_sat, m_err;
    logic [15:0] m_cnt;

    // Saturation instance
    logic        s_d, s_valid, s_clr;
    logic        s_we = 1'b0;
    logic [7:0]  s_pat = 8'h00;
    logic [3:0]  s_len = 4'd0;
    logic        s_ovl = 1'b0;
    logic        s_det, s_sat, s_err;
    logic [1:0]  s_cnt;

    seq_pattern_detector u_dut (
        .clk_i              (clk),
        .rst_i              (rst_n),
        .d_i                (m_d),
        .valid_i            (m_valid),
        .cfg_we_i           (m_we),
        .cfg_pattern_i      (m_pat),
        .cfg_len_i          (m_len),
        .cfg_overlap_i      (m_ovl),
        .clear_i            (m_clr),
        .pattern_detected_o (m_det),
        .match_count_o      (m_cnt),
        .count_sat_o        (m_sat),
        .cfg_err_o          (m_err)
    );

    seq_pattern_detector #(
        .CNT_W       (2),
        .RST_PATTERN (8'b0000_0001),
        .RST_LEN     (1),
        .RST_OVERLAP (1'b1)
    ) u_sat (
        .clk_i              (clk),
        .rst_i              (rst_n),
        .d_i                (s_d),
        .valid_i            (s_valid),
        .cfg_we_i           (s_we),
        .cfg_pattern_i      (s_pat),
        .cfg_len_i          (s_len),
        .cfg_overlap_i      (s_ovl),
        .clear_i            (s_clr),
        .pattern_detected_o (s_det),
        .match_count_o      (s_cnt),
        .count_sat_o        (s_sat),
        .cfg_err_o          (s_err)
    );

    typedef struct {
        bit          sel;
        int          idx;
        logic        det;
        logic        err;
        logic [15:0] cnt;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   txn_no = 0;

    // Reference counter state per instance
    int   m_exp_cnt = 0;
    bit   m_exp_sat = 1'b0;
    int   s_exp_cnt = 0;
    bit   s_exp_sat = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock of stimulus on the selected instance plus its expectation.
    task automatic step(input bit sel, input logic v, input logic d, input logic we,
                        input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                        input logic clr, input logic exp_det);
        exp_t e;
        int   c;
        bit   s;
        int   mx;
        @(negedge clk);
        m_valid = 1'b0; m_d = 1'b0; m_we = 1'b0; m_clr = 1'b0;
        s_valid = 1'b0; s_d = 1'b0; s_clr = 1'b0;
        if (sel == 1'b0) begin
            m_valid = v; m_d = d; m_we = we; m_pat = pat; m_len = len; m_ovl = ovl; m_clr = clr;
        end else begin
            s_valid = v; s_d = d; s_clr = clr;
        end
        @(posedge clk);
        if (sel) begin c = s_exp_cnt; s = s_exp_sat; mx = 3; end
        else     begin c = m_exp_cnt; s = m_exp_sat; mx = 65535; end
        if (clr) begin
            c = 0;
            s = 1'b0;
        end else if (exp_det && c < mx) begin
            c++;
            if (c == mx) s = 1'b1;
        end
        if (sel) begin s_exp_cnt = c; s_exp_sat = s; end
        else     begin m_exp_cnt = c; m_exp_sat = s; end
        txn_no++;
        e.sel = sel;
        e.idx = txn_no;
        e.det = exp_det;
        e.err = we && ((len == 4'd0) || (len > 4'd8));
        e.cnt = 16'(c);
        e.sat = s;
        sb.push_back(e);
    endtask

    task automatic bit_m(input logic d, input logic exp_det);
        step(1'b0, 1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, exp_det);
    endtask

    task automatic cfg_m(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                         input logic v, input logic d);
        step(1'b0, v, d, 1'b1, pat, len, ovl, 1'b0, 1'b0);
    endtask

    task automatic bit_s(input logic d, input logic clr, input logic exp_det);
        step(1'b1, 1'b1, d, 1'b0, 8'h00, 4'd0, 1'b0, clr, exp_det);
    endtask

    // Scoreboard monitor: outputs are stable here, half a cycle after the edge.
    always @(negedge clk) begin : mon
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 1'b0) begin
                $display("txn %0d main det=%b cnt=%0d sat=%b err=%b", e.idx, m_det, m_cnt, m_sat, m_err);
                chk($sformatf("main_det#%0d", e.idx), 32'(m_det), 32'(e.det));
                chk($sformatf("main_cnt#%0d", e.idx), 32'(m_cnt), 32'(e.cnt));
                chk($sformatf("main_sat#%0d", e.idx), 32'(m_sat), 32'(e.sat));
                chk($sformatf("main_err#%0d", e.idx), 32'(m_err), 32'(e.err));
            end else begin
                $display("txn %0d sat  det=%b cnt=%0d sat=%b err=%b", e.idx, s_det, s_cnt, s_sat, s_err);
                chk($sformatf("sat_det#%0d", e.idx), 32'(s_det), 32'(e.det));
                chk($sformatf("sat_cnt#%0d", e.idx), 32'(s_cnt), 32'(e.cnt));
                chk($sformatf("sat_sat#%0d", e.idx), 32'(s_sat), 32'(e.sat));
                chk($sformatf("sat_err#%0d", e.idx), 32'(s_err), 32'(e.err));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit t1_d [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
        bit t1_e [8] = '{0, 0, 0, 0, 1, 0, 0, 1};
        bit t2_d [6] = '{1, 0, 1, 0, 1, 0};
        bit t2_e0[6] = '{0, 0, 0, 1, 0, 0};
        bit t2_e1[6] = '{0, 0, 0, 1, 0, 1};

        m_d = 0; m_valid = 0; m_we = 0; m_pat = '0; m_len = '0; m_ovl = 0; m_clr = 0;
        s_d = 0; s_valid = 0; s_clr = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_det", 32'(m_det), 32'd0);
        chk("rst_cnt", 32'(m_cnt), 32'd0);
        chk("rst_sat", 32'(m_sat), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_scnt", 32'(s_cnt), 32'd0);

        // Reset default 11011, overlap
        for (int i = 0; i < 8; i++) bit_m(t1_d[i], t1_e[i]);

        // 1010, non-overlap then overlap
        cfg_m(8'b0000_1010, 4'd4, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) bit_m(t2_d[i], t2_e0[i]);
        cfg_m(8'b0000_1010, 4'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) bit_m(t2_d[i], t2_e1[i]);

        // 0110 non-overlap with a valid gap mid-pattern
        cfg_m(8'b0000_0110, 4'd4, 1'b0, 1'b0, 1'b0);
        bit_m(1'b0, 1'b0);
        bit_m(1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b0, 1'b1);
        // Config collides with the completing bit: it is discarded, fill restarts
        bit_m(1'b0, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b1, 1'b0);
        cfg_m(8'b0000_0110, 4'd4, 1'b0, 1'b1, 1'b0);
        bit_m(1'b0, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b0, 1'b1);

        // Illegal lengths rejected; 0110 still active
        cfg_m(8'hFF, 4'd0, 1'b1, 1'b1, 1'b1);
        cfg_m(8'hFF, 4'd9, 1'b1, 1'b1, 1'b1);
        bit_m(1'b0, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b0, 1'b1);

        // Saturation and clear-vs-match on the 2-bit counter instance
        for (int i = 0; i < 5; i++) bit_s(1'b1, 1'b0, 1'b1);
        bit_s(1'b1, 1'b1, 1'b1);
        bit_s(1'b0, 1'b0, 1'b0);
        bit_s(1'b1, 1'b0, 1'b1);

        // Async reset in the middle of a pattern
        bit_m(1'b1, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_det", 32'(m_det), 32'd0);
        chk("arst_cnt", 32'(m_cnt), 32'd0);
        chk("arst_sat", 32'(m_sat), 32'd0);
        chk("arst_err", 32'(m_err), 32'd0);
        chk("arst_scnt", 32'(s_cnt), 32'd0);
        m_exp_cnt = 0; m_exp_sat = 1'b0;
        s_exp_cnt = 0; s_exp_sat = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bit_m(1'b1, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b0, 1'b0);
        bit_m(1'b1, 1'b0);
        bit_m(1'b1, 1'b1);

        repeat (2) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
